// File: rtl/nd_1to2.sv
`default_nettype none

`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 32
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 32
`endif

// ============================================================================
// Module   : nd_1to2
// Purpose  : 1-to-2 split node. Each message arriving on the rcv0 channel is
//            routed to snd0 or snd1 by address bit RBIT. Every output owns a
//            message FIFO, so a stalled consumer only blocks the other side
//            once its own FIFO is full (the input is head-of-line).
// Ports    : i_clk                 rising-edge clock
//            reset                 synchronous active-high reset
//            ready                 node initialised after reset
//            snd0_addr/data/req    output 0 message and request
//            snd0_ack              output 0 acknowledge
//            snd1_addr/data/req    output 1 message and request
//            snd1_ack              output 1 acknowledge
//            rcv0_addr/data/req    input message and request
//            rcv0_ack              input acknowledge
//            All channels use a 4-phase req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nd_1to2 #(
  parameter int FSZ  = `NS_MESSAGE_FIFO_SIZE,
  parameter int ASZ  = `NS_ADDRESS_SIZE,
  parameter int DSZ  = `NS_DATA_SIZE,
  parameter int RBIT = 0
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  output logic [ASZ-1:0] snd0_addr,
  output logic [DSZ-1:0] snd0_data,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd1_addr,
  output logic [DSZ-1:0] snd1_data,
  output logic           snd1_req,
  input  logic           snd1_ack,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_data,
  input  logic           rcv0_req,
  output logic           rcv0_ack
);

  localparam int c_PW = $clog2(FSZ);      // FIFO pointer width
  localparam int c_CW = $clog2(FSZ) + 1;  // occupancy count width (0..FSZ)
  localparam int c_MW = ASZ + DSZ;        // stored message width

  logic       r_ready;
  logic       r_rcv_ack;
  logic       w_run;
  logic       w_pending;
  logic       w_tgt;
  logic       w_accept;
  logic [1:0] w_wr;
  logic [1:0] w_snd_ack;

  assign w_run     = r_ready & ~reset;
  // A new message is only pending while the previous handshake is closed;
  // the req qualifier also keeps an undriven address from reaching the FIFOs.
  assign w_pending = rcv0_req & ~r_rcv_ack;
  assign w_tgt     = rcv0_addr[RBIT];
  assign w_accept  = |w_wr;
  assign w_snd_ack = {snd1_ack, snd0_ack};

  // --------------------------------------------------------------------------
  // Ready flag and input acknowledge
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_ready <= 1'b0;
    end else if (!r_ready) begin
      r_ready   <= 1'b1;
      r_rcv_ack <= 1'b0;
    end else if (w_accept) begin
      r_rcv_ack <= 1'b1;
    end else if (!rcv0_req && r_rcv_ack) begin
      r_rcv_ack <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // One FIFO plus output channel per destination
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 2; k++) begin : g_out
    logic [c_MW-1:0] r_mem [FSZ];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            r_req;
    logic [ASZ-1:0]  r_addr;
    logic [DSZ-1:0]  r_data;
    logic            w_full;
    logic            w_rd;

    // Full is judged on the registered count, so a read on this edge does
    // not make room for a write on the same edge.
    assign w_full  = (r_count == c_CW'(FSZ));
    assign w_wr[k] = w_run & w_pending & (w_tgt == 1'(k)) & ~w_full;
    // Launch only once the previous handshake has fully closed.
    assign w_rd    = w_run & ~r_req & ~w_snd_ack[k] & (r_count != '0);

    always_ff @(posedge i_clk) begin
      if (w_wr[k]) begin
        r_mem[r_head] <= {rcv0_addr, rcv0_data};
      end
    end

    always_ff @(posedge i_clk) begin
      if (!reset) begin
        if (!r_ready) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          r_req   <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
        end else begin
          if (w_wr[k]) begin
            r_head <= r_head + 1'b1;  // power-of-2 depth wraps naturally
          end
          if (w_rd) begin
            {r_addr, r_data} <= r_mem[r_tail];
            r_req            <= 1'b1;
            r_tail           <= r_tail + 1'b1;
          end else if (r_req && w_snd_ack[k]) begin
            r_req <= 1'b0;
          end
          r_count <= r_count + c_CW'(w_wr[k]) - c_CW'(w_rd);
        end
      end
    end
  end

  assign ready     = r_ready;
  assign rcv0_ack  = r_rcv_ack;
  assign snd0_addr = g_out[0].r_addr;
  assign snd0_data = g_out[0].r_data;
  assign snd0_req  = g_out[0].r_req;
  assign snd1_addr = g_out[1].r_addr;
  assign snd1_data = g_out[1].r_data;
  assign snd1_req  = g_out[1].r_req;

endmodule

`default_nettype wire
